// File: rtl/hit_row_decoder_pkg.sv
// Shared parameters and state encoding for the hit storage and readout stages.
package hit_row_decoder_pkg;

   localparam int ADDRESSNBITS = 16;
   localparam int COLINDEXBITS = 5;
   localparam int ROWINDEXBITS = ADDRESSNBITS - COLINDEXBITS;
   localparam int NCOLS        = 2 ** COLINDEXBITS;
   localparam int HITCOUNTBITS = 12;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } decoder_state_t;

endpackage

// File: rtl/hit_row_decoder_lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit of a row word plus an any-bit flag.
module lowest_set_bit_encoder
   import hit_row_decoder_pkg::*;
(
   input  logic [NCOLS-1:0]        bits,
   output logic [COLINDEXBITS-1:0] index,
   output logic                    any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      index = '0;
      any   = 1'b0;
      for (int c = NCOLS - 1; c >= 0; c--) begin
         if (bits[c]) begin
            index = COLINDEXBITS'(c);
            any   = 1'b1;
         end else begin
            index = index;
            any   = any;
         end
      end
   end

endmodule

// File: rtl/hit_row_decoder.sv
// Re-serialises hit bitmap rows into hit addresses, lowest column first.
// Optional feature macro: HIT_COUNT_EN (per-pass hit total on hitTotal).
module hit_row_decoder
   import hit_row_decoder_pkg::*;
`ifdef HIT_COUNT_EN
#(
   parameter int HITBITS = HITCOUNTBITS
)
`endif
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    rowValid,
   output logic                    rowReady,
   input  logic [ROWINDEXBITS-1:0] rowIndex,
   input  logic [NCOLS-1:0]        rowData,
   input  logic                    rowLast,
   output logic                    addressValid,
   input  logic                    addressReady,
   output logic [ADDRESSNBITS-1:0] address,
   output logic                    readoutDone
`ifdef HIT_COUNT_EN
   ,
   output logic [HITBITS-1:0]      hitTotal
`endif
);

   decoder_state_t            state, state_n;
   logic [NCOLS-1:0]          pending, pending_n, pending_cleared;
   logic [ROWINDEXBITS-1:0]   held_row, held_row_n;
   logic                      last_flag, last_n;
   logic                      ready_n, valid_n, done_n;
   logic [ADDRESSNBITS-1:0]   address_n;
   logic [NCOLS-1:0]          enc_in;
   logic [COLINDEXBITS-1:0]   enc_index;
   logic                      enc_any;
   logic                      handshake;

   lowest_set_bit_encoder u_encoder (
      .bits  (enc_in),
      .index (enc_index),
      .any   (enc_any)
   );

   assign handshake = (state == EMIT) && addressValid && addressReady;

   // Next-state logic; the encoder looks at the incoming row in IDLE and at the
   // bits left after the current handshake in EMIT, so the next address is ready one edge later.
   always_comb begin
      state_n         = state;
      pending_n       = pending;
      held_row_n      = held_row;
      last_n          = last_flag;
      ready_n         = rowReady;
      valid_n         = addressValid;
      address_n       = address;
      done_n          = 1'b0;
      pending_cleared = pending & (pending - {{(NCOLS-1){1'b0}}, 1'b1});
      enc_in          = rowData;
      case (state)
         IDLE: begin
            enc_in  = rowData;
            ready_n = 1'b1;
            valid_n = 1'b0;
            if (rowValid && rowReady) begin
               pending_n  = rowData;
               held_row_n = rowIndex;
               last_n     = rowLast;
               if (enc_any) begin
                  state_n   = EMIT;
                  valid_n   = 1'b1;
                  ready_n   = 1'b0;
                  address_n = {rowIndex, enc_index};
               end else begin
                  done_n = rowLast;
               end
            end else begin
               state_n = IDLE;
            end
         end
         EMIT: begin
            enc_in = pending_cleared;
            if (addressReady) begin
               pending_n = pending_cleared;
               if (enc_any) begin
                  address_n = {held_row, enc_index};
               end else begin
                  state_n = IDLE;
                  valid_n = 1'b0;
                  ready_n = 1'b1;
                  done_n  = last_flag;
               end
            end else begin
               state_n = EMIT;
            end
         end
         default: begin
            state_n   = IDLE;
            pending_n = '0;
            valid_n   = 1'b0;
            ready_n   = 1'b1;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         pending      <= '0;
         held_row     <= '0;
         last_flag    <= 1'b0;
         rowReady     <= 1'b0;
         addressValid <= 1'b0;
         address      <= '0;
         readoutDone  <= 1'b0;
      end else begin
         state        <= state_n;
         pending      <= pending_n;
         held_row     <= held_row_n;
         last_flag    <= last_n;
         rowReady     <= ready_n;
         addressValid <= valid_n;
         address      <= address_n;
         readoutDone  <= done_n;
      end
   end

`ifdef HIT_COUNT_EN
   localparam logic [HITBITS-1:0] COUNT_MAX = {HITBITS{1'b1}};

   logic [HITBITS-1:0] hit_count, hit_count_n;

   // Saturating handshake count; the current edge's handshake is included when the pass closes.
   always_comb begin
      if (handshake && (hit_count != COUNT_MAX)) begin
         hit_count_n = hit_count + HITBITS'(1);
      end else begin
         hit_count_n = hit_count;
      end
   end

   // Publish the total on the same edge that raises readoutDone.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_count <= '0;
         hitTotal  <= '0;
      end else if (done_n) begin
         hit_count <= '0;
         hitTotal  <= hit_count_n;
      end else begin
         hit_count <= hit_count_n;
         hitTotal  <= hitTotal;
      end
   end
`endif

endmodule

// File: tb/tb_hit_row_decoder.sv
// Directed self-checking bench for hit_row_decoder (hitTotal checks only with HIT_COUNT_EN).
module tb_hit_row_decoder;
   import hit_row_decoder_pkg::*;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    rowValid;
   logic                    rowReady;
   logic [ROWINDEXBITS-1:0] rowIndex;
   logic [NCOLS-1:0]        rowData;
   logic                    rowLast;
   logic                    addressValid;
   logic                    addressReady;
   logic [ADDRESSNBITS-1:0] address;
   logic                    readoutDone;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

`ifdef HIT_COUNT_EN
   logic [1:0] hitTotal;
   hit_row_decoder #(.HITBITS(2)) dut (
      .clock(clock), .reset(reset), .rowValid(rowValid), .rowReady(rowReady),
      .rowIndex(rowIndex), .rowData(rowData), .rowLast(rowLast),
      .addressValid(addressValid), .addressReady(addressReady), .address(address),
      .readoutDone(readoutDone), .hitTotal(hitTotal));
`else
   hit_row_decoder dut (
      .clock(clock), .reset(reset), .rowValid(rowValid), .rowReady(rowReady),
      .rowIndex(rowIndex), .rowData(rowData), .rowLast(rowLast),
      .addressValid(addressValid), .addressReady(addressReady), .address(address),
      .readoutDone(readoutDone));
`endif

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic present(input int row, input logic [31:0] data, input logic last);
      rowValid = 1'b1;
      rowIndex = ROWINDEXBITS'(row);
      rowData  = data;
      rowLast  = last;
   endtask

   task automatic emit_chk(input string tag, input int addr);
      chk({tag, "_valid"}, {31'd0, addressValid}, 32'd1);
      chk({tag, "_addr"}, {16'd0, address}, addr);
   endtask

   initial begin
      reset        = 1'b1;
      rowValid     = 1'b0;
      rowIndex     = '0;
      rowData      = '0;
      rowLast      = 1'b0;
      addressReady = 1'b1;
      tick();
      tick();
      chk("rst_ready", {31'd0, rowReady}, 32'd0);
      chk("rst_valid", {31'd0, addressValid}, 32'd0);
      chk("rst_addr", {16'd0, address}, 32'd0);
      chk("rst_done", {31'd0, readoutDone}, 32'd0);
`ifdef HIT_COUNT_EN
      chk("rst_total", {30'd0, hitTotal}, 32'd0);
`endif
      reset = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, rowReady}, 32'd1);

      // Empty last row: no address, done pulse next cycle.
      present(0, 32'h0000_0000, 1'b1);
      tick();
      rowValid = 1'b0;
      chk("empty_done", {31'd0, readoutDone}, 32'd1);
      chk("empty_valid", {31'd0, addressValid}, 32'd0);
      chk("empty_ready", {31'd0, rowReady}, 32'd1);
`ifdef HIT_COUNT_EN
      chk("empty_total", {30'd0, hitTotal}, 32'd0);
`endif
      tick();
      chk("empty_done_end", {31'd0, readoutDone}, 32'd0);

      // Three-row pass: 32, 33, (empty row 2), 226, then one done pulse.
      present(1, 32'h0000_0003, 1'b0);
      tick();
      rowValid = 1'b0;
      emit_chk("p3_a0", 32);
      chk("p3_busy", {31'd0, rowReady}, 32'd0);
      tick();
      emit_chk("p3_a1", 33);
      tick();
      chk("p3_idle_ready", {31'd0, rowReady}, 32'd1);
      chk("p3_idle_valid", {31'd0, addressValid}, 32'd0);
      present(2, 32'h0000_0000, 1'b0);
      tick();
      rowValid = 1'b0;
      chk("p3_zero_ready", {31'd0, rowReady}, 32'd1);
      chk("p3_zero_valid", {31'd0, addressValid}, 32'd0);
      chk("p3_zero_done", {31'd0, readoutDone}, 32'd0);
      present(7, 32'h0000_0004, 1'b1);
      tick();
      rowValid = 1'b0;
      emit_chk("p3_a2", 226);
      chk("p3_early_done", {31'd0, readoutDone}, 32'd0);
      tick();
      chk("p3_done", {31'd0, readoutDone}, 32'd1);
      chk("p3_valid_off", {31'd0, addressValid}, 32'd0);
`ifdef HIT_COUNT_EN
      chk("p3_total", {30'd0, hitTotal}, 32'd3);
`endif
      tick();
      chk("p3_done_end", {31'd0, readoutDone}, 32'd0);

      // Row 3, 0x12: addresses 97 and 100 back to back.
      present(3, 32'h0000_0012, 1'b0);
      tick();
      rowValid = 1'b0;
      emit_chk("r3_a0", 97);
      tick();
      emit_chk("r3_a1", 100);
      tick();
      chk("r3_ready", {31'd0, rowReady}, 32'd1);
      chk("r3_valid_off", {31'd0, addressValid}, 32'd0);
      chk("r3_no_done", {31'd0, readoutDone}, 32'd0);

      // Row 5, 0x80000001 with back-pressure: 160 held, then 160, 191.
      present(5, 32'h8000_0001, 1'b0);
      addressReady = 1'b0;
      tick();
      rowValid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         emit_chk("bp_hold", 160);
         tick();
      end
      addressReady = 1'b1;
      emit_chk("bp_a0", 160);
      tick();
      emit_chk("bp_a1", 191);
      tick();
      chk("bp_valid_off", {31'd0, addressValid}, 32'd0);
      chk("bp_ready", {31'd0, rowReady}, 32'd1);
      chk("bp_no_done", {31'd0, readoutDone}, 32'd0);

      // Reset mid-emit of row 4, 0xFF after two handshakes.
      present(4, 32'h0000_00FF, 1'b1);
      tick();
      rowValid = 1'b0;
      emit_chk("mr_a0", 128);
      tick();
      emit_chk("mr_a1", 129);
      tick();
      emit_chk("mr_a2", 130);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_valid", {31'd0, addressValid}, 32'd0);
      chk("mr_addr", {16'd0, address}, 32'd0);
      chk("mr_done", {31'd0, readoutDone}, 32'd0);
      tick();
      chk("mr_done2", {31'd0, readoutDone}, 32'd0);
      chk("mr_ready", {31'd0, rowReady}, 32'd1);

      // Row 0, 0x1F last: addresses 0..4, then done (total saturates at 3 on a 2-bit counter).
      present(0, 32'h0000_001F, 1'b1);
      tick();
      rowValid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         emit_chk("sat_addr", i);
         chk("sat_no_done", {31'd0, readoutDone}, 32'd0);
         tick();
      end
      chk("sat_done", {31'd0, readoutDone}, 32'd1);
      chk("sat_valid_off", {31'd0, addressValid}, 32'd0);
`ifdef HIT_COUNT_EN
      chk("sat_total", {30'd0, hitTotal}, 32'd3);
`endif
      tick();
      chk("sat_done_end", {31'd0, readoutDone}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
